store_checker: RTL
==================

Name: store_checker

Overview:
- Synthesizable in-order scoreboard that sits directly downstream of the core's data-memory store port (MemWrite/DataAdr/WriteData).
- Compares every committed store against a preloaded expected-store table and counts passes.
- Detects the end-of-program store and reports PASS/FAIL plus diagnostics.
- Used for FPGA self-check runs and as a drop-in monitor under the processor testbench.

Parameters:
DEPTH, 64, number of expected-store entries
IDX_W, 6, index width, log2(DEPTH)
DONE_ADR, 40, address of the terminating store
DONE_DATA, 30, data value of the terminating store
IGN_LO, 96, lowest address of the ignored scratch window (inclusive)
IGN_HI, 99, highest address of the ignored scratch window (inclusive)
TIMEOUT, 4096, max cycles in RUN without an accepted store

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high
MemWrite  in  1  core store strobe, valid at rising edge
DataAdr  in  32  store byte address
WriteData  in  32  store data
ExpWe  in  1  write one expected-table entry
ExpIdx  in  IDX_W  table index for ExpWe
ExpAdr  in  32  expected address
ExpData  in  32  expected data
NumExp  in  IDX_W+1  number of valid entries; sampled on start
start  in  1  begin a check run
busy  out  1  high in RUN
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS only
pass_count  out  IDX_W+1  matched stores so far
fail_code  out  2  0 none, 1 mismatch/extra, 2 early done, 3 timeout
fail_idx  out  IDX_W+1  table index at failure
fail_adr  out  32  offending DataAdr (0 for timeout)
fail_data  out  32  offending WriteData (0 for timeout)

Behaviour:
- Reset (any time, including mid-run):
  - state=IDLE; all outputs 0; idx, timer and num_r cleared.
  - Table contents are not cleared.
- States IDLE, RUN, PASS, FAIL. All outputs are registered and reflect the state one cycle after the causing edge.
- IDLE:
  - ExpWe writes table[ExpIdx] <= {ExpAdr, ExpData}.
  - start -> RUN: idx=0, pass_count=0, timer=0, num_r=NumExp (clamped to DEPTH), fail fields cleared.
  - MemWrite in IDLE, including the start cycle, is ignored.
- RUN, evaluated on each rising edge where MemWrite=1, in priority order:
  1. IGN_LO <= DataAdr <= IGN_HI: ignored. No idx change, timer not reset.
  2. DataAdr==DONE_ADR and WriteData==DONE_DATA:
     - idx==num_r -> PASS.
     - otherwise -> FAIL, code 2.
  3. idx<num_r and DataAdr==table[idx].adr and WriteData==table[idx].data: idx+1, pass_count+1, timer=0.
  4. Anything else, including a store when idx==num_r: FAIL, code 1, capture idx/DataAdr/WriteData.
- Timer:
  - Increments every RUN cycle without an accepted store (case 3).
  - timer reaching TIMEOUT-1 with no store that cycle -> FAIL, code 3, fail_idx=idx.
  - A case-3 match in the same cycle takes priority over timeout.
- ExpWe and start are ignored in RUN.
- PASS/FAIL are sticky:
  - start -> RUN, re-initialising as from IDLE.
  - ExpWe is accepted in PASS/FAIL.
- All compares are full 32-bit equality; no sign handling.
- Table is a synchronous-write array; the read of table[idx] is combinational from the registered idx.
- Address/data compare uses the value in the table at the edge; a same-cycle ExpWe cannot occur in RUN.

Test Plan:
- Load 3 entries {100,25},{104,4096},{108,4184}, NumExp=3, start; drive those stores then {40,30} -> pass=1, done=1, pass_count=3, fail_code=0.
- Same table; second store is {104,4097} -> FAIL next cycle, fail_code=1, fail_idx=1, fail_adr=104, fail_data=4097, pass_count=1.
- Same table; after 2 matches drive {40,30} -> fail_code=2, fail_idx=2.
- Interleave stores to addresses 96,97,98,99 between matches -> ignored, final PASS with pass_count=3.
- start with no stores for 4096 cycles -> fail_code=3, fail_idx=0. A store matching entry 0 at cycle 4095 instead resets the timer and there is no fail.
- Assert reset mid-RUN after 2 matches -> all outputs 0 immediately. Re-start with the table retained and full sequence -> PASS, pass_count=3.

Source files
------------

// File: rtl/store_checker_if.sv
// Bundle of the core store port, expected-table load port, run control and
// check status shared between a driver (core/testbench) and store_checker.
`timescale 1ns/1ps
interface store_checker_if #(
  parameter int IDX_W = 6
);
  // core data-memory store port
  logic              MemWrite;
  logic [31:0]       DataAdr;
  logic [31:0]       WriteData;
  // expected-store table load port
  logic              ExpWe;
  logic [IDX_W-1:0]  ExpIdx;
  logic [31:0]       ExpAdr;
  logic [31:0]       ExpData;
  // run control
  logic [IDX_W:0]    NumExp;
  logic              start;
  // check status
  logic              busy;
  logic              done;
  logic              pass;
  logic [IDX_W:0]    pass_count;
  logic [1:0]        fail_code;
  logic [IDX_W:0]    fail_idx;
  logic [31:0]       fail_adr;
  logic [31:0]       fail_data;

  modport master (
    output MemWrite, DataAdr, WriteData,
    output ExpWe, ExpIdx, ExpAdr, ExpData,
    output NumExp, start,
    input  busy, done, pass, pass_count,
    input  fail_code, fail_idx, fail_adr, fail_data
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData,
    input  ExpWe, ExpIdx, ExpAdr, ExpData,
    input  NumExp, start,
    output busy, done, pass, pass_count,
    output fail_code, fail_idx, fail_adr, fail_data
  );
endinterface

// File: rtl/store_checker.sv
// In-order store scoreboard: compares each committed core store against a
// preloaded expected-store table, ignores a scratch address window, and
// reports PASS/FAIL with diagnostics when the terminating store is seen,
// a store is wrong, or the core goes quiet for too long.
`timescale 1ns/1ps
module store_checker #(
  parameter int          DEPTH     = 64,
  parameter int          IDX_W     = 6,
  parameter logic [31:0] DONE_ADR  = 32'd40,
  parameter logic [31:0] DONE_DATA = 32'd30,
  parameter logic [31:0] IGN_LO    = 32'd96,
  parameter logic [31:0] IGN_HI    = 32'd99,
  parameter int          TIMEOUT   = 4096
) (
  input  logic           clk,
  input  logic           reset,
  store_checker_if.slave bus
);

  localparam int              TW         = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [IDX_W:0]  DEPTH_N    = (IDX_W + 1)'(DEPTH);

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_EARLY    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t          state;
  state_t          state_n;

  logic [IDX_W:0]  idx;
  logic [IDX_W:0]  num_r;
  logic [TW-1:0]   timer;

  logic [1:0]      fail_code_r;
  logic [IDX_W:0]  fail_idx_r;
  logic [31:0]     fail_adr_r;
  logic [31:0]     fail_data_r;

  // each entry packs {address, data}
  logic [63:0]     exp_table [DEPTH];

  logic [31:0]     cur_adr;
  logic [31:0]     cur_data;
  logic            is_ignored;
  logic            is_done_store;
  logic            is_match;
  logic            accept;
  logic [1:0]      fail_n;
  logic [IDX_W:0]  num_clamped;

  // entry at the current position, read combinationally from the registered idx
  assign {cur_adr, cur_data} = exp_table[idx[IDX_W-1:0]];

  assign is_ignored    = (bus.DataAdr >= IGN_LO) && (bus.DataAdr <= IGN_HI);
  assign is_done_store = (bus.DataAdr == DONE_ADR) && (bus.WriteData == DONE_DATA);
  assign is_match      = (idx < num_r) && (bus.DataAdr == cur_adr) && (bus.WriteData == cur_data);
  assign num_clamped   = (bus.NumExp > DEPTH_N) ? DEPTH_N : bus.NumExp;

  // expected-table writes are only honoured while not checking a run
  always_ff @(posedge clk) begin
    if (bus.ExpWe && (state != ST_RUN)) begin
      exp_table[bus.ExpIdx] <= {bus.ExpAdr, bus.ExpData};
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // next state plus the per-edge verdict: accepted store or failure cause
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    fail_n  = FC_NONE;
    case (state)
      ST_RUN: begin
        if (bus.MemWrite && !is_ignored) begin
          if (is_done_store) begin
            if (idx == num_r) begin
              state_n = ST_PASS;
            end else begin
              state_n = ST_FAIL;
              fail_n  = FC_EARLY;
            end
          end else if (is_match) begin
            accept = 1'b1;
          end else begin
            state_n = ST_FAIL;
            fail_n  = FC_MISMATCH;
          end
        end else if (timer == TIMER_LAST) begin
          state_n = ST_FAIL;
          fail_n  = FC_TIMEOUT;
        end
      end
      default: begin
        if (bus.start) begin
          state_n = ST_RUN;
        end
      end
    endcase
  end

  // run bookkeeping: table position, quiet-cycle timer and failure capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      num_r       <= '0;
      timer       <= '0;
      fail_code_r <= FC_NONE;
      fail_idx_r  <= '0;
      fail_adr_r  <= '0;
      fail_data_r <= '0;
    end else if (state != ST_RUN) begin
      if (bus.start) begin
        idx         <= '0;
        num_r       <= num_clamped;
        timer       <= '0;
        fail_code_r <= FC_NONE;
        fail_idx_r  <= '0;
        fail_adr_r  <= '0;
        fail_data_r <= '0;
      end
    end else begin
      if (accept) begin
        idx   <= idx + 1'b1;
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      if (fail_n != FC_NONE) begin
        fail_code_r <= fail_n;
        fail_idx_r  <= idx;
        fail_adr_r  <= (fail_n == FC_TIMEOUT) ? 32'd0 : bus.DataAdr;
        fail_data_r <= (fail_n == FC_TIMEOUT) ? 32'd0 : bus.WriteData;
      end
    end
  end

  // status flags decoded from the registered state
  always_comb begin
    bus.busy = (state == ST_RUN);
    bus.done = (state == ST_PASS) || (state == ST_FAIL);
    bus.pass = (state == ST_PASS);
  end

  assign bus.pass_count = idx;
  assign bus.fail_code  = fail_code_r;
  assign bus.fail_idx   = fail_idx_r;
  assign bus.fail_adr   = fail_adr_r;
  assign bus.fail_data  = fail_data_r;

endmodule
